// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: runs one register read or write per command and returns the result on a response port.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to compile in the bus timeout (TIMEOUT_CYC cycles from accept to aborted response).
module axil_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("axil_cmd_master: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYC must be at least 2");
    end

    // Every channel (cmd, rsp, AW, W, B, AR, R): a transfer happens on the rising edge where
    // VALID && READY; once VALID is raised it stays high, payload unchanged, until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              state, state_d;
    logic                aw_pend, aw_pend_d;
    logic                w_pend, w_pend_d;
    logic                cmd_ready_q;
    logic                accept, cap_b, cap_r, tmo_fire, tmo_hit;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state       <= state_d;
            aw_pend     <= aw_pend_d;
            w_pend      <= w_pend_d;
            cmd_ready_q <= (state_d == IDLE);
        end
    end

    // A handshake arriving in the timeout cycle wins over the abort.
    always_comb begin
        state_d   = state;
        aw_pend_d = aw_pend;
        w_pend_d  = w_pend;
        accept    = 1'b0;
        cap_b     = 1'b0;
        cap_r     = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept    = 1'b1;
                    aw_pend_d = cmd_write;
                    w_pend_d  = cmd_write;
                    state_d   = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                aw_pend_d = aw_pend && !m_awready;
                w_pend_d  = w_pend && !m_wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_RESP;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    aw_pend_d = 1'b0;
                    w_pend_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    cap_b   = 1'b1;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = RESP;
                end
            end
            RD_REQ: begin
                if (m_arready) begin
                    state_d = RD_DATA;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = RESP;
                end
            end
            RD_DATA: begin
                if (m_rvalid) begin
                    cap_r   = 1'b1;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else if (cap_b) begin
            resp_q  <= m_bresp;
        end else if (cap_r) begin
            rdata_q <= m_rdata;
            resp_q  <= m_rresp;
        end else if (tmo_fire) begin
            rdata_q <= '0;
            resp_q  <= 2'b10;
        end
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout_q;

    // The abort edge takes the count to TIMEOUT_CYC-1, so rsp_valid rises TIMEOUT_CYC cycles after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (tmo_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 2));
    assign rsp_timeout = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = (state == WR_REQ) && aw_pend;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = (state == WR_REQ) && w_pend;
    assign m_bready  = (state == WR_RESP);
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = (state == RD_REQ);
    assign m_rready  = (state == RD_DATA);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: memory-backed AXI4-Lite slave with programmable per-channel wait states,
// reference model of expected responses and latency, randomized command stream.
module tb_axil_cmd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TMO_CYC = 16;
    localparam int NEVER   = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] m_awaddr, m_araddr;
    logic [2:0]        m_awprot, m_arprot;
    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [1:0]        m_bresp, m_rresp;

    axil_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_mem[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- slave model ----------------
    int cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0, cfg_ar_lat = 0, cfg_r_lat = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int aw_age, w_age, ar_age, b_age, r_age;
    logic aw_seen, w_seen, b_pend, b_drop, r_pend, r_drop;
    logic [ADDR_W-1:0] got_awaddr, got_araddr;
    logic [DATA_W-1:0] got_wdata;
    logic [STRB_W-1:0] got_wstrb;
    logic [DATA_W-1:0] slv_mem[16];

    task automatic slave_clear();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0; b_drop = 0; r_pend = 0; r_drop = 0;
    endtask

    // Slave decides at each falling edge; a READY raised while VALID is high means a transfer at the next rising edge.
    initial begin : slave
        slave_clear();
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_clear();
            end else begin
                if (b_drop) begin
                    m_bvalid = 0; b_drop = 0;
                end else if (b_pend) begin
                    if (b_age >= cfg_b_lat) begin
                        m_bvalid = 1; m_bresp = cfg_bresp; b_pend = 0;
                    end else b_age++;
                end
                if (m_bvalid && m_bready) begin b_hs++; b_drop = 1; end

                if (r_drop) begin
                    m_rvalid = 0; r_drop = 0;
                end else if (r_pend) begin
                    if (r_age >= cfg_r_lat) begin
                        m_rvalid = 1; m_rdata = slv_mem[got_araddr[5:2]]; m_rresp = cfg_rresp; r_pend = 0;
                    end else r_age++;
                end
                if (m_rvalid && m_rready) begin r_hs++; r_drop = 1; end

                m_awready = 0;
                if (m_awvalid) begin
                    if (aw_age >= cfg_aw_lat) begin
                        m_awready = 1; aw_hs++; got_awaddr = m_awaddr; aw_seen = 1;
                    end
                    aw_age++;
                end else aw_age = 0;

                m_wready = 0;
                if (m_wvalid) begin
                    if (w_age >= cfg_w_lat) begin
                        m_wready = 1; w_hs++; got_wdata = m_wdata; got_wstrb = m_wstrb; w_seen = 1;
                    end
                    w_age++;
                end else w_age = 0;

                if (aw_seen && w_seen) begin
                    slv_mem[got_awaddr[5:2]] = merge(slv_mem[got_awaddr[5:2]], got_wdata, got_wstrb);
                    aw_seen = 0; w_seen = 0; b_pend = 1; b_age = 0;
                end

                m_arready = 0;
                if (m_arvalid) begin
                    if (ar_age >= cfg_ar_lat) begin
                        m_arready = 1; ar_hs++; got_araddr = m_araddr; r_pend = 1; r_age = 0;
                    end
                    ar_age++;
                end else ar_age = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // Called on a falling edge; returns on the falling edge after the response is consumed.
    task automatic run_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [STRB_W-1:0] strb, input int hold);
        int lat, exp_lat, n, idx;
        logic [1:0] exp_resp;
        logic exp_tmo;
        logic [DATA_W-1:0] exp_rdata;
        idx = int'(addr[5:2]);
        exp_tmo = 1'b0;
        if (wr) begin
            exp_mem[idx] = merge(exp_mem[idx], data, strb);
            exp_q.push_back('0);
            exp_resp = cfg_bresp;
            exp_lat  = 3 + ((cfg_aw_lat > cfg_w_lat) ? cfg_aw_lat : cfg_w_lat) + cfg_b_lat;
        end else if (cfg_ar_lat >= NEVER) begin
            exp_q.push_back('0);
            exp_resp = 2'b10;
            exp_tmo  = 1'b1;
            exp_lat  = TMO_CYC;
        end else begin
            exp_q.push_back(exp_mem[idx]);
            exp_resp = cfg_rresp;
            exp_lat  = 3 + cfg_ar_lat + cfg_r_lat;
        end
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;

        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = STRB_W'($urandom);
        check("cmd_ready_drop", cmd_ready, 0);
        check("busy_high", busy, 1);

        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        check("rsp_latency", lat, exp_lat);
        exp_rdata = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_resp", rsp_resp, exp_resp);
        check("rsp_timeout", rsp_timeout, exp_tmo);
        check("bus_quiet", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_resp", rsp_resp, exp_resp);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_consumed", rsp_valid, 0);
        check("cmd_ready_rise", cmd_ready, 1);
        check("busy_low", busy, 0);

        check("aw_handshakes", aw_hs, wr ? 1 : 0);
        check("w_handshakes", w_hs, wr ? 1 : 0);
        check("b_handshakes", b_hs, wr ? 1 : 0);
        check("ar_handshakes", ar_hs, (wr || exp_tmo) ? 0 : 1);
        check("r_handshakes", r_hs, (wr || exp_tmo) ? 0 : 1);
        if (wr) begin
            check("awaddr", got_awaddr, addr);
            check("wdata", got_wdata, data);
            check("wstrb", got_wstrb, strb);
        end else if (!exp_tmo) begin
            check("araddr", got_araddr, addr);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        rst = 1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
        for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; exp_mem[i] = '0; end
        slv_mem[8] = 32'h1234_5678;
        exp_mem[8] = 32'h1234_5678;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", rsp_timeout, 0);
        check("rst_bus_valid_ready", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        check("rst_addr", {m_awaddr, m_araddr}, 0);
        check("rst_wdata", {m_wdata, m_wstrb}, 0);
        check("rst_rsp_data", {rsp_rdata, rsp_resp}, 0);
        check("prot", {m_awprot, m_arprot}, 0);
        rst = 0;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        run_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        run_cmd(1'b0, 32'h20, '0, '0, 0);
        run_cmd(1'b0, 32'h10, '0, '0, 1);

        cfg_aw_lat = 4; cfg_w_lat = 0;
        run_cmd(1'b1, 32'h14, 32'hCAFE_0001, 4'hF, 0);
        cfg_aw_lat = 0; cfg_w_lat = 4;
        run_cmd(1'b1, 32'h18, 32'hCAFE_0002, 4'b0011, 0);
        cfg_w_lat = 0;

        cfg_rresp = 2'b10;
        run_cmd(1'b0, 32'h14, '0, '0, 3);
        cfg_rresp = 2'b00;

        run_cmd(1'b1, 32'h30, 32'h0BAD_F00D, 4'b0101, 5);
        run_cmd(1'b0, 32'h30, '0, '0, 0);

        // Reset while the master waits in the write-response phase.
        cfg_b_lat = 10;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h08; cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!m_bready && n < 50) begin @(negedge clk); n++; end
        check("bready_before_reset", m_bready, 1);
        exp_mem[2] = merge(exp_mem[2], 32'hA5A5_0F0F, 4'hF);
        #2 rst = 1;
        #1;
        check("async_rst_bready", m_bready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        cfg_b_lat = 0;
        run_cmd(1'b0, 32'h08, '0, '0, 0);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        cfg_ar_lat = NEVER;
        run_cmd(1'b0, 32'h24, '0, '0, 2);
        cfg_ar_lat = 0;
        run_cmd(1'b0, 32'h20, '0, '0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            cfg_aw_lat = $urandom_range(0, 3);
            cfg_w_lat  = $urandom_range(0, 3);
            cfg_b_lat  = $urandom_range(0, 3);
            cfg_ar_lat = $urandom_range(0, 3);
            cfg_r_lat  = $urandom_range(0, 3);
            cfg_bresp  = 2'($urandom_range(0, 3));
            cfg_rresp  = 2'($urandom_range(0, 3));
            run_cmd(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15) << 2), $urandom,
                    STRB_W'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Synthesisable, parametrised AXI4-Lite master. Executes one register read or write per command taken from a simple valid/ready command port, then returns the result on a valid/ready response port.
- Replaces task-based bench-only bus driving, so that on-chip sequencers and bench command streams use the same RTL master.
- Generalised in address/data width. AW and W are accepted independently. BRESP/RRESP is reported. A bus timeout can be compiled in.

Parameters:
- ADDR_W, 32, address width (AWADDR/ARADDR and cmd_addr).
- DATA_W, 32, data width; legal values 32 or 64; STRB_W = DATA_W/8 (derived, not overridable).
- TIMEOUT_CYC, 1024, timeout limit in cycles (used only with the optional feature); minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  STRB_W  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP; 2'b10 forced on timeout
- rsp_timeout  out  1  transaction aborted by timeout
- busy  out  1  high in any state other than IDLE
- m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready, m_araddr, m_arvalid, m_arready, m_rdata, m_rresp, m_rvalid, m_rready: standard AXI4-Lite master signals, widths per ADDR_W/DATA_W/STRB_W. m_awprot and m_arprot tied to 3'b000.

Behaviour:
- Reset: all VALID/READY outputs, cmd_ready, rsp_valid, rsp_timeout and busy are 0. All address/data/resp outputs are 0. State is IDLE.
- cmd_ready is registered. It is 1 only in IDLE with rsp_valid low, and drops the cycle after acceptance.
- States and transitions:
  - IDLE: on command accept, latch all cmd_* fields.
    - Write: next state WR_REQ, m_awvalid=m_wvalid=1.
    - Read: next state RD_REQ, m_arvalid=1.
  - WR_REQ: m_awvalid drops in the cycle after its own handshake; m_wvalid likewise. Handshakes may occur in the same or different cycles, in either order. VALID is never deasserted before its READY. When both handshakes are done, next state WR_RESP with m_bready=1.
  - WR_RESP: on m_bvalid&&m_bready, capture m_bresp, drop m_bready, next state RESP.
  - RD_REQ: on m_arready, drop m_arvalid, next state RD_DATA with m_rready=1.
  - RD_DATA: on m_rvalid&&m_rready, capture m_rdata and m_rresp, drop m_rready, next state RESP.
  - RESP: rsp_valid=1, outputs held stable until rsp_ready. Then next state IDLE, and cmd_ready rises the following cycle.
- Latency: with a slave ready in zero wait states, there are 3 cycles from command accept to rsp_valid for both reads and writes.
- Only one outstanding transaction.
- m_bready and m_rready are asserted only after address acceptance, never speculatively.
- Address and data outputs hold their latched values while VALID is high. They are not required to clear afterwards.
- rsp_rdata is 0 for writes.
- Response codes SLVERR/DECERR are passed through unchanged. The master does not retry.
- Reset mid-transaction aborts immediately and clears all VALID/READY outputs. A slave left with a pending handshake is the system's problem.

Optional Feature:
- Macro AXIL_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR_REQ/RD_REQ and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - Reaching TIMEOUT_CYC-1 without completion deasserts all master VALID/READY and enters RESP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - A handshake completing in the timeout cycle takes precedence: normal completion, no timeout.
- Undefined: no counter exists, rsp_timeout is tied to 0, and the master waits indefinitely.

Test Plan:
- Write with zero-wait slave, addr 0x10, data 0xDEADBEEF, strb 0xF:
  - Single AW/W handshake with those values.
  - rsp_valid 3 cycles after accept, rsp_resp=0, rsp_rdata=0.
- Read of addr 0x20, slave returns 0x12345678, RRESP=0: rsp_rdata=0x12345678, rsp_resp=0.
- Write with slave accepting W 4 cycles before AW, then reversed ordering:
  - m_wvalid drops after its own handshake.
  - Exactly one handshake per channel, B accepted, correct completion.
- Read where slave returns RRESP=2'b10: rsp_resp=2'b10, rsp_timeout=0; next command accepted only after rsp_ready.
- rsp_ready held low 5 cycles:
  - rsp_* stable, cmd_ready=0 throughout.
  - Reset asserted mid-WR_RESP clears m_bready, busy and rsp_valid asynchronously.
- With AXIL_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, slave never asserts ARREADY: abort 16 cycles after accept, rsp_resp=2'b10, rsp_timeout=1, m_arvalid=0.
